// File: rtl/dma_ch_apb_regif.sv
// dma_ch_apb_regif: APB4 completer for one DMA channel's register block.
// Optional `CH_WRITE_PROTECT_EN: config writes (0x008-0x088) are rejected while the channel is enabled.
module dma_ch_apb_regif #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 12,
    parameter int RD_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [ADDR_W-1:0]    PADDR,
    input  logic [WIDTH-1:0]     PWDATA,
    input  logic [WIDTH/8-1:0]   PSTRB,
    output logic                 PREADY,
    output logic [WIDTH-1:0]     PRDATA,
    output logic                 PSLVERR,
    output logic [WIDTH*15-1:0]  data_out,
    output logic [WIDTH-1:0]     cfg_WRKREGPTR,
    input  logic [WIDTH*12-1:0]  chn_reg_in,
    input  logic [WIDTH*3-1:0]   src_des_xsize_in,
    input  logic [WIDTH-1:0]     wrkregval_in,
    input  logic                 ch_enabled
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t            state, state_nx;
    logic [1:0]        cnt, cnt_nx;
    logic [WIDTH-1:0]  sh [2:15];
    logic [WIDTH-1:6]  cmd_hi;
    logic [5:0]        cmd_p;
    logic [3:0]        st_p;
    logic [WIDTH-1:0]  rd_q, rd_d, wmask, wdata;
    logic [3:0]        widx;
    logic              mapped, ro, prot, err, commit;
    logic [ADDR_W-1:0] addr;
    assign addr  = {PADDR[ADDR_W-1:2], 2'b00};
    assign wdata = PWDATA & wmask;
    for (genvar b = 0; b < WIDTH/8; b++) begin : g_mask
        assign wmask[8*b +: 8] = {8{PSTRB[b]}};
    end
    // widx: write-image word (0..14) or 15 for WRKREGPTR; ro marks read-only words
    always_comb begin
        widx   = '0;
        mapped = 1'b1;
        ro     = 1'b0;
        rd_d   = '0;
        case (addr)
            ADDR_W'('h000): rd_d = chn_reg_in[11*WIDTH +: WIDTH];
            ADDR_W'('h004): begin widx = 4'd1;  rd_d = chn_reg_in[10*WIDTH +: WIDTH]; end
            ADDR_W'('h008): begin widx = 4'd2;  rd_d = sh[2]; end
            ADDR_W'('h00C): begin widx = 4'd3;  rd_d = chn_reg_in[9*WIDTH +: WIDTH]; end
            ADDR_W'('h010): begin widx = 4'd4;  rd_d = src_des_xsize_in[2*WIDTH +: WIDTH]; end
            ADDR_W'('h018): begin widx = 4'd5;  rd_d = src_des_xsize_in[WIDTH +: WIDTH]; end
            ADDR_W'('h020): begin widx = 4'd6;  rd_d = src_des_xsize_in[0 +: WIDTH]; end
            ADDR_W'('h028): begin widx = 4'd7;  rd_d = chn_reg_in[8*WIDTH +: WIDTH]; end
            ADDR_W'('h02C): begin widx = 4'd8;  rd_d = chn_reg_in[7*WIDTH +: WIDTH]; end
            ADDR_W'('h030): begin widx = 4'd9;  rd_d = chn_reg_in[6*WIDTH +: WIDTH]; end
            ADDR_W'('h038): begin widx = 4'd10; rd_d = chn_reg_in[5*WIDTH +: WIDTH]; end
            ADDR_W'('h04C): begin widx = 4'd11; rd_d = chn_reg_in[4*WIDTH +: WIDTH]; end
            ADDR_W'('h050): begin widx = 4'd12; rd_d = chn_reg_in[3*WIDTH +: WIDTH]; end
            ADDR_W'('h054): begin widx = 4'd13; rd_d = chn_reg_in[2*WIDTH +: WIDTH]; end
            ADDR_W'('h078): begin widx = 4'd14; rd_d = chn_reg_in[WIDTH +: WIDTH]; end
            ADDR_W'('h088): begin widx = 4'd15; rd_d = sh[15]; end
            ADDR_W'('h08C): begin ro = 1'b1;    rd_d = wrkregval_in; end
            ADDR_W'('h090): begin ro = 1'b1;    rd_d = chn_reg_in[0 +: WIDTH]; end
            default:        mapped = 1'b0;
        endcase
    end
`ifdef CH_WRITE_PROTECT_EN
    assign prot = PWRITE && ch_enabled && widx >= 4'd2;
`else
    logic unused_ch_enabled;
    assign unused_ch_enabled = ch_enabled;
    assign prot = 1'b0;
`endif
    assign err = !mapped || PADDR[1:0] != 2'b00 || (PWRITE && ro) || prot;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            state_nx = (PSEL && !PENABLE) ? ACCESS : IDLE;
            cnt_nx   = PWRITE ? 2'd0 : 2'(RD_WAIT);
        end else begin
            state_nx = (!PSEL || (PENABLE && cnt == 2'd0)) ? IDLE : ACCESS;
            cnt_nx   = (PSEL && PENABLE && cnt != 2'd0) ? cnt - 2'd1 : cnt;
        end
    end
    always_comb begin
        PREADY  = resetn && state == ACCESS && PSEL && PENABLE && cnt == 2'd0;
        PSLVERR = PREADY && err;
        PRDATA  = (PREADY && !err && !PWRITE) ? rd_q : '0;
        commit  = PREADY && PWRITE && !err;
    end
    // command and W1C bits are single-cycle pulses; everything else is a byte-masked shadow
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_q   <= '0;
            cmd_hi <= '0;
            cmd_p  <= '0;
            st_p   <= '0;
            for (int i = 2; i < 16; i++) sh[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            cmd_p <= (commit && widx == 4'd0) ? wdata[5:0] : '0;
            st_p  <= (commit && widx == 4'd1) ? wdata[19:16] : '0;
            if (commit && widx == 4'd0) cmd_hi <= (cmd_hi & ~wmask[WIDTH-1:6]) | wdata[WIDTH-1:6];
            for (int i = 2; i < 16; i++)
                if (commit && widx == 4'(i)) sh[i] <= (sh[i] & ~wmask) | wdata;
        end
    end
    assign data_out[0 +: WIDTH]     = {cmd_hi, cmd_p};
    assign data_out[WIDTH +: WIDTH] = WIDTH'({st_p, 16'h0000});
    for (genvar g = 2; g < 15; g++) begin : g_img
        assign data_out[g*WIDTH +: WIDTH] = sh[g];
    end
    assign cfg_WRKREGPTR = sh[15];
endmodule

// File: tb/tb_dma_ch_apb_regif.sv
// tb_dma_ch_apb_regif: random APB traffic against a table-driven register model of the channel frame.
module tb_dma_ch_apb_regif;
    localparam int W = 32;
    localparam int RD_WAIT = 1;
    typedef logic [479:0] v_t;
    logic clk = 1'b0, resetn = 1'b0;
    logic PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [11:0] PADDR = '0;
    logic [W-1:0] PWDATA = '0;
    logic [3:0] PSTRB = '0;
    logic PREADY, PSLVERR;
    logic [W-1:0] PRDATA, cfg_WRKREGPTR;
    logic [W*15-1:0] data_out;
    logic [W*12-1:0] chn_reg_in = '0;
    logic [W*3-1:0] src_des_xsize_in = '0;
    logic [W-1:0] wrkregval_in = '0;
    logic ch_enabled = 1'b0;
    int n_vec = 0, n_err = 0;
    dma_ch_apb_regif #(.WIDTH(W), .ADDR_W(12), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .resetn(resetn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
        .PSLVERR(PSLVERR), .data_out(data_out), .cfg_WRKREGPTR(cfg_WRKREGPTR),
        .chn_reg_in(chn_reg_in), .src_des_xsize_in(src_des_xsize_in),
        .wrkregval_in(wrkregval_in), .ch_enabled(ch_enabled));
    always #5 clk = ~clk;
    // entries 0..14 are write-image words, 15 WRKREGPTR, 16 WRKREGVAL, 17 ERRINFO
    logic [11:0] map_addr [18] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h018,
        12'h020, 12'h028, 12'h02C, 12'h030, 12'h038, 12'h04C, 12'h050, 12'h054, 12'h078,
        12'h088, 12'h08C, 12'h090};
    logic [W-1:0] m_sh [16];
    logic [5:0] m_pc;
    logic [3:0] m_ps;
    task automatic chk(input string tag, input v_t got, input v_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int lookup(input logic [11:0] a);
        for (int k = 0; k < 18; k++) if (map_addr[k] == a) return k;
        return -1;
    endfunction
    function automatic logic [W-1:0] chn(input int k);
        return chn_reg_in[k*W +: W];
    endfunction
    function automatic logic [W-1:0] exp_rd(input int j);
        case (j)
            0: return chn(11);
            1: return chn(10);
            2, 15: return m_sh[j];
            3: return chn(9);
            4, 5, 6: return src_des_xsize_in[(6-j)*W +: W];
            14: return chn(1);
            16: return wrkregval_in;
            17: return chn(0);
            default: return chn(15 - j);
        endcase
    endfunction
    function automatic v_t image(input bit p);
        v_t v;
        v = '0;
        v[31:0] = {m_sh[0][31:6], p ? m_pc : 6'd0};
        v[63:32] = p ? {12'd0, m_ps, 16'd0} : 32'd0;
        for (int k = 2; k < 15; k++) v[k*W +: W] = m_sh[k];
        return v;
    endfunction
    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_sh[k] = '0;
        m_pc = '0;
        m_ps = '0;
    endtask
    task automatic model_write(input int j, input logic [W-1:0] d, input logic [3:0] s);
        logic [W-1:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (j == 1) m_ps = s[2] ? d[19:16] : 4'd0;
        else m_sh[j] = (m_sh[j] & ~m) | (d & m);
        if (j == 0) m_pc = s[0] ? d[5:0] : 6'd0;
    endtask
    task automatic rand_inputs();
        for (int k = 0; k < 12; k++) chn_reg_in[k*W +: W] = $urandom;
        for (int k = 0; k < 3; k++) src_des_xsize_in[k*W +: W] = $urandom;
        wrkregval_in = $urandom;
    endtask
    task automatic apb(input bit wr, input logic [11:0] a, input logic [W-1:0] d, input logic [3:0] s,
                       output logic [W-1:0] rd, output logic er, output int waits);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        waits = 0;
        rd = '0;
        er = 1'b0;
        forever begin
            @(negedge clk);
            if (PREADY) begin
                rd = PRDATA;
                er = PSLVERR;
                break;
            end
            waits++;
            if (waits > 8) begin
                chk("pready_timeout", v_t'(waits), v_t'(RD_WAIT));
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask
    task automatic xfer(input bit wr, input logic [11:0] a, input logic [W-1:0] d, input logic [3:0] s);
        logic [W-1:0] rd, e_rd;
        logic er;
        int waits, j;
        bit e_err;
        j = lookup(a);
        e_err = (j < 0) || (wr && j >= 16);
`ifdef CH_WRITE_PROTECT_EN
        e_err = e_err || (wr && ch_enabled && j >= 2);
`endif
        e_rd = (!wr && !e_err) ? exp_rd(j) : '0;
        m_pc = '0;
        m_ps = '0;
        apb(wr, a, d, s, rd, er, waits);
        chk("waits", v_t'(waits), v_t'(wr ? 0 : RD_WAIT));
        chk("pslverr", v_t'(er), v_t'(e_err));
        chk("prdata", v_t'(rd), v_t'(e_rd));
        if (wr && !e_err) model_write(j, d, s);
        @(negedge clk);
        chk("image_pulse", data_out, image(1'b1));
        chk("wrkregptr", v_t'(cfg_WRKREGPTR), v_t'(m_sh[15]));
        @(negedge clk);
        chk("image_after", data_out, image(1'b0));
    endtask
    initial begin
        model_reset();
        rand_inputs();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_pready", v_t'(PREADY), '0);
        chk("rst_prdata", v_t'(PRDATA), '0);
        chk("rst_pslverr", v_t'(PSLVERR), '0);
        chk("rst_image", data_out, '0);
        chk("rst_wrkptr", v_t'(cfg_WRKREGPTR), '0);
        xfer(1'b0, 12'h00C, '0, 4'hF);
        xfer(1'b1, 12'h000, 32'hA5A5_5A41, 4'hF);
        xfer(1'b1, 12'h000, 32'h0000_0001, 4'h1);
        xfer(1'b1, 12'h004, 32'h000F_0000, 4'b0100);
        xfer(1'b1, 12'h010, 32'hDEAD_BEEF, 4'b0011);
        xfer(1'b0, 12'h0FC, '0, 4'hF);
        xfer(1'b1, 12'h08C, 32'h1234_5678, 4'hF);
        xfer(1'b1, 12'h00A, 32'h1234_5678, 4'hF);
        ch_enabled = 1'b1;
        xfer(1'b1, 12'h00C, 32'hCAFE_F00D, 4'hF);
        xfer(1'b1, 12'h000, 32'h0000_0010, 4'hF);
        xfer(1'b1, 12'h088, 32'h0000_0003, 4'hF);
        ch_enabled = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [11:0] a;
            rand_inputs();
            ch_enabled = 1'($urandom);
            r = $urandom_range(0, 9);
            a = map_addr[$urandom_range(0, 17)];
            if (r == 7) a = a | 12'($urandom_range(1, 3));
            if (r >= 8) a = 12'($urandom);
            xfer(1'($urandom_range(0, 2) != 0), a, $urandom, 4'($urandom));
        end
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
        @(posedge clk); #1;
        PSEL = 1'b0;
        @(negedge clk);
        chk("abort_pready", v_t'(PREADY), '0);
        @(negedge clk);
        chk("abort_image", data_out, image(1'b0));
        xfer(1'b0, 12'h008, '0, 4'hF);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h00C;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_pready", v_t'(PREADY), '0);
        chk("rstmid_image", data_out, '0);
        chk("rstmid_wrkptr", v_t'(cfg_WRKREGPTR), '0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        model_reset();
        xfer(1'b0, 12'h008, '0, 4'hF);
        xfer(1'b1, 12'h000, 32'h0000_003F, 4'h1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
